// File: rtl/ga_pkg.sv
// Shared types and defaults for the GA pipeline: controller state encoding,
// default widths, and the child-address stepping rule that skips the elite slot.
package ga_pkg;

  localparam int DEF_POPULATION_SIZE = 16;
  localparam int DEF_FITNESS_WIDTH   = 14;
  localparam int DEF_MAX_GENERATIONS = 100;
  localparam int DEF_TIMEOUT_CYCLES  = 255;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_GEN_START,
    ST_SELECT,
    ST_FETCH,
    ST_CROSS,
    ST_MUTATE,
    ST_EVAL,
    ST_WRITE,
    ST_GEN_END,
    ST_DONE
  } ga_ctrl_state_t;

  // Next child destination; the elite slot is stepped over so it survives the generation.
  function automatic logic [31:0] next_write_addr(input logic [31:0] addr, input logic [31:0] elite);
    logic [31:0] n;
    n = addr + 32'd1;
    if (n == elite) n = n + 32'd1;
    return n;
  endfunction

endpackage

// File: rtl/ga_generation_controller_if.sv
// Stage handshake bundle between the generation controller (master) and the
// selection / crossover / mutation / fitness units plus population memory (slave).
interface ga_generation_controller_if #(
  parameter int ADDR_WIDTH    = 4,
  parameter int FITNESS_WIDTH = 14
);
  logic                     start_selection;
  logic                     selection_done;
  logic [ADDR_WIDTH-1:0]    selected_index1;
  logic [ADDR_WIDTH-1:0]    selected_index2;
  logic [ADDR_WIDTH-1:0]    read_addr1;
  logic [ADDR_WIDTH-1:0]    read_addr2;
  logic                     start_crossover;
  logic                     crossover_done;
  logic                     start_mutation;
  logic                     mutation_done;
  logic                     start_fitness;
  logic                     fitness_done;
  logic [FITNESS_WIDTH-1:0] child_fitness;
  logic                     write_en;
  logic [ADDR_WIDTH-1:0]    write_addr;

  modport master (
    output start_selection, read_addr1, read_addr2, start_crossover,
           start_mutation, start_fitness, write_en, write_addr,
    input  selection_done, selected_index1, selected_index2, crossover_done,
           mutation_done, fitness_done, child_fitness
  );

  modport slave (
    input  start_selection, read_addr1, read_addr2, start_crossover,
           start_mutation, start_fitness, write_en, write_addr,
    output selection_done, selected_index1, selected_index2, crossover_done,
           mutation_done, fitness_done, child_fitness
  );
endinterface

// File: rtl/ga_stage_timer.sv
// Watchdog for stage waits: counts enabled cycles since the last clear and
// flags expiry in the cycle that completes TIMEOUT_CYCLES of waiting.
module ga_stage_timer #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] count_q, count_d;

  assign expired = enable && (count_q >= CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    count_d = count_q;
    if (clear) count_d = '0;
    else if (enable && !expired) count_d = count_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end
endmodule

// File: rtl/ga_generation_controller.sv
// Sequences GA generations: select -> fetch -> crossover -> mutate -> evaluate ->
// write per child, preserving one elite slot and tracking best fitness.
module ga_generation_controller
  import ga_pkg::*;
#(
  parameter int POPULATION_SIZE = DEF_POPULATION_SIZE,
  parameter int ADDR_WIDTH      = $clog2(POPULATION_SIZE),
  parameter int FITNESS_WIDTH   = DEF_FITNESS_WIDTH,
  parameter int MAX_GENERATIONS = DEF_MAX_GENERATIONS,
  parameter int GEN_WIDTH       = $clog2(MAX_GENERATIONS + 1),
  parameter int TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_ga,
  input  logic [FITNESS_WIDTH-1:0] target_fitness,
  input  logic [ADDR_WIDTH-1:0]    pop_best_index,
  input  logic [FITNESS_WIDTH-1:0] pop_best_fitness,
  ga_generation_controller_if.master bus,
  output logic [GEN_WIDTH-1:0]     generation_count,
  output logic [FITNESS_WIDTH-1:0] best_fitness,
  output logic [ADDR_WIDTH-1:0]    best_index,
  output logic                     busy,
  output logic                     ga_done,
  output logic                     target_reached,
  output logic                     timeout_error
);
  localparam logic [ADDR_WIDTH-1:0] TOP_ADDR = ADDR_WIDTH'(POPULATION_SIZE - 1);

  ga_ctrl_state_t           state_q, state_d;
  logic [FITNESS_WIDTH-1:0] target_q, target_d;
  logic [FITNESS_WIDTH-1:0] best_fit_q, best_fit_d;
  logic [ADDR_WIDTH-1:0]    best_idx_q, best_idx_d;
  logic [ADDR_WIDTH-1:0]    elite_q, elite_d;
  logic [ADDR_WIDTH-1:0]    write_addr_q, write_addr_d;
  logic [ADDR_WIDTH-1:0]    read_addr1_q, read_addr1_d;
  logic [ADDR_WIDTH-1:0]    read_addr2_q, read_addr2_d;
  logic [FITNESS_WIDTH-1:0] child_fit_q, child_fit_d;
  logic [GEN_WIDTH-1:0]     gen_q, gen_d;
  logic start_sel_q, start_sel_d, start_cross_q, start_cross_d;
  logic start_mut_q, start_mut_d, start_fit_q, start_fit_d;
  logic write_en_q, write_en_d, ga_done_q, ga_done_d;
  logic target_reached_q, target_reached_d, timeout_q, timeout_d;

  logic                  timer_clear, timer_enable, timer_expired;
  logic [ADDR_WIDTH-1:0] last_addr;

  // Watchdog restarts on every state change and only runs while waiting on a unit.
  assign timer_clear  = (state_d != state_q);
  assign timer_enable = (state_q == ST_SELECT) || (state_q == ST_CROSS) ||
                        (state_q == ST_MUTATE) || (state_q == ST_EVAL);

  ga_stage_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (timer_clear),
    .enable  (timer_enable),
    .expired (timer_expired)
  );

  assign last_addr = (elite_q == TOP_ADDR) ? TOP_ADDR - ADDR_WIDTH'(1) : TOP_ADDR;

  always_comb begin
    state_d          = state_q;
    target_d         = target_q;
    best_fit_d       = best_fit_q;
    best_idx_d       = best_idx_q;
    elite_d          = elite_q;
    write_addr_d     = write_addr_q;
    read_addr1_d     = read_addr1_q;
    read_addr2_d     = read_addr2_q;
    child_fit_d      = child_fit_q;
    gen_d            = gen_q;
    target_reached_d = target_reached_q;
    timeout_d        = timeout_q;
    start_sel_d      = 1'b0;
    start_cross_d    = 1'b0;
    start_mut_d      = 1'b0;
    start_fit_d      = 1'b0;
    write_en_d       = 1'b0;

    case (state_q)
      ST_IDLE: if (start_ga) begin
        state_d          = ST_GEN_START;
        target_d         = target_fitness;
        best_fit_d       = pop_best_fitness;
        best_idx_d       = pop_best_index;
        gen_d            = '0;
        target_reached_d = 1'b0;
        timeout_d        = 1'b0;
      end
      ST_GEN_START: begin
        elite_d      = best_idx_q;
        write_addr_d = (best_idx_q == '0) ? ADDR_WIDTH'(1) : '0;
        state_d      = ST_SELECT;
        start_sel_d  = 1'b1;
      end
      ST_SELECT: if (bus.selection_done) begin
        read_addr1_d  = bus.selected_index1;
        read_addr2_d  = bus.selected_index2;
        state_d       = ST_FETCH;
      end else if (timer_expired) begin
        timeout_d = 1'b1;
        state_d   = ST_DONE;
      end
      ST_FETCH: begin
        state_d       = ST_CROSS;
        start_cross_d = 1'b1;
      end
      ST_CROSS: if (bus.crossover_done) begin
        state_d     = ST_MUTATE;
        start_mut_d = 1'b1;
      end else if (timer_expired) begin
        timeout_d = 1'b1;
        state_d   = ST_DONE;
      end
      ST_MUTATE: if (bus.mutation_done) begin
        state_d     = ST_EVAL;
        start_fit_d = 1'b1;
      end else if (timer_expired) begin
        timeout_d = 1'b1;
        state_d   = ST_DONE;
      end
      ST_EVAL: if (bus.fitness_done) begin
        child_fit_d = bus.child_fitness;
        state_d     = ST_WRITE;
        write_en_d  = 1'b1;
      end else if (timer_expired) begin
        timeout_d = 1'b1;
        state_d   = ST_DONE;
      end
      ST_WRITE: begin
        if (child_fit_q > best_fit_q) begin
          best_fit_d = child_fit_q;
          best_idx_d = write_addr_q;
        end
        if (child_fit_q >= target_q) begin
          target_reached_d = 1'b1;
          state_d          = ST_DONE;
        end else if (write_addr_q == last_addr) begin
          state_d = ST_GEN_END;
        end else begin
          write_addr_d = ADDR_WIDTH'(next_write_addr(32'(write_addr_q), 32'(elite_q)));
          state_d      = ST_SELECT;
          start_sel_d  = 1'b1;
        end
      end
      ST_GEN_END: begin
        if (gen_q != GEN_WIDTH'(MAX_GENERATIONS)) gen_d = gen_q + GEN_WIDTH'(1);
        state_d = (gen_d == GEN_WIDTH'(MAX_GENERATIONS)) ? ST_DONE : ST_GEN_START;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    ga_done_d = (state_d == ST_DONE) && (state_q != ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= ST_IDLE;
      target_q         <= '0;
      best_fit_q       <= '0;
      best_idx_q       <= '0;
      elite_q          <= '0;
      write_addr_q     <= '0;
      read_addr1_q     <= '0;
      read_addr2_q     <= '0;
      child_fit_q      <= '0;
      gen_q            <= '0;
      start_sel_q      <= 1'b0;
      start_cross_q    <= 1'b0;
      start_mut_q      <= 1'b0;
      start_fit_q      <= 1'b0;
      write_en_q       <= 1'b0;
      ga_done_q        <= 1'b0;
      target_reached_q <= 1'b0;
      timeout_q        <= 1'b0;
    end else begin
      state_q          <= state_d;
      target_q         <= target_d;
      best_fit_q       <= best_fit_d;
      best_idx_q       <= best_idx_d;
      elite_q          <= elite_d;
      write_addr_q     <= write_addr_d;
      read_addr1_q     <= read_addr1_d;
      read_addr2_q     <= read_addr2_d;
      child_fit_q      <= child_fit_d;
      gen_q            <= gen_d;
      start_sel_q      <= start_sel_d;
      start_cross_q    <= start_cross_d;
      start_mut_q      <= start_mut_d;
      start_fit_q      <= start_fit_d;
      write_en_q       <= write_en_d;
      ga_done_q        <= ga_done_d;
      target_reached_q <= target_reached_d;
      timeout_q        <= timeout_d;
    end
  end

  assign bus.start_selection = start_sel_q;
  assign bus.start_crossover = start_cross_q;
  assign bus.start_mutation  = start_mut_q;
  assign bus.start_fitness   = start_fit_q;
  assign bus.read_addr1      = read_addr1_q;
  assign bus.read_addr2      = read_addr2_q;
  assign bus.write_en        = write_en_q;
  assign bus.write_addr      = write_addr_q;
  assign generation_count    = gen_q;
  assign best_fitness        = best_fit_q;
  assign best_index          = best_idx_q;
  assign busy                = (state_q != ST_IDLE);
  assign ga_done             = ga_done_q;
  assign target_reached      = target_reached_q;
  assign timeout_error       = timeout_q;
endmodule
